// File: rtl/pc_fetch_sequencer.sv
// Program-counter owner and instruction fetch sequencer (req/ack imem handshake).
// Optional macro PC_BRANCH_SIGN_EXT_EN: sign-extend branch immediates (zero-extend when undefined).
module pc_fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          W        = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         stall,
   input  logic         branch_taken,
   input  logic         jump,
   input  logic         jr,
   input  logic [W-1:0] jr_target,
   output logic         imem_req,
   output logic [W-1:0] imem_addr,
   input  logic         imem_ack,
   input  logic [W-1:0] imem_rdata,
   output logic [W-1:0] instr,
   output logic         instr_valid,
   output logic [W-1:0] pc,
   output logic [W-1:0] pc_plus4
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_REQ   = 2'b01,
      S_VALID = 2'b10
   } state_t;

   state_t         state_r;
   logic [W-1:0]   pc_r;
   logic [W-1:0]   instr_r;
   logic           instr_valid_r;
   logic [W-1:0]   pc_plus4_s;
   logic [W-1:0]   branch_off_s;
   logic [W-1:0]   next_pc_s;

   // Branch immediate extension; must match the downstream extend unit's mode.
   function automatic logic [31:0] ext16(input logic [15:0] imm);
`ifdef PC_BRANCH_SIGN_EXT_EN
      ext16 = {{16{imm[15]}}, imm};
`else
      ext16 = {16'h0000, imm};
`endif
   endfunction

   assign pc_plus4_s   = pc_r + 32'd4;
   assign branch_off_s = ext16(instr_r[15:0]) << 2;

   // Next-PC select: jr over jump over taken branch over sequential.
   always_comb begin
      next_pc_s = pc_plus4_s;
      if (jr) begin
         next_pc_s = jr_target & 32'hFFFF_FFFC;
      end else if (jump) begin
         next_pc_s = {pc_plus4_s[31:28], instr_r[25:0], 2'b00};
      end else if (branch_taken) begin
         next_pc_s = pc_plus4_s + branch_off_s;
      end else begin
         next_pc_s = pc_plus4_s;
      end
   end

   // Fetch FSM with registered pc/instr/instr_valid; acks outside S_REQ are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= S_IDLE;
         pc_r          <= RESET_PC;
         instr_r       <= 32'h0000_0000;
         instr_valid_r <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               state_r <= S_REQ;
            end
            S_REQ: begin
               if (imem_ack) begin
                  instr_r       <= imem_rdata;
                  instr_valid_r <= 1'b1;
                  state_r       <= S_VALID;
               end
            end
            S_VALID: begin
               if (!stall) begin
                  pc_r          <= next_pc_s;
                  instr_valid_r <= 1'b0;
                  state_r       <= S_REQ;
               end
            end
            default: begin
               state_r       <= S_IDLE;
               instr_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req    = (state_r == S_REQ);
   assign imem_addr   = pc_r;
   assign instr       = instr_r;
   assign instr_valid = instr_valid_r;
   assign pc          = pc_r;
   assign pc_plus4    = pc_plus4_s;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed, table-driven bench for pc_fetch_sequencer (honours PC_BRANCH_SIGN_EXT_EN).
module tb_pc_fetch_sequencer;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        branch_taken;
   logic        jump;
   logic        jr;
   logic [31:0] jr_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;

   int pass_cnt;
   int total_cnt;

   typedef struct {
      logic [31:0] word;
      logic        br;
      logic        jmp;
      logic        jrr;
      logic [31:0] jrt;
      logic [31:0] nxt;
   } vec_t;

   vec_t vecs [12];

   pc_fetch_sequencer #(.RESET_PC(32'h0000_0000), .W(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall        (stall),
      .branch_taken (branch_taken),
      .jump         (jump),
      .jr           (jr),
      .jr_target    (jr_target),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ack     (imem_ack),
      .imem_rdata   (imem_rdata),
      .instr        (instr),
      .instr_valid  (instr_valid),
      .pc           (pc),
      .pc_plus4     (pc_plus4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act !== exp) begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end else begin
         pass_cnt++;
      end
   endtask

   task automatic set_vec(input int i, input logic [31:0] word, input logic br, input logic jmp,
                          input logic jrr, input logic [31:0] jrt, input logic [31:0] nxt);
      vecs[i].word = word;
      vecs[i].br   = br;
      vecs[i].jmp  = jmp;
      vecs[i].jrr  = jrr;
      vecs[i].jrt  = jrt;
      vecs[i].nxt  = nxt;
   endtask

   task automatic wait_req();
      for (int i = 0; i < 20 && imem_req !== 1'b1; i++) @(negedge clk);
      if (imem_req !== 1'b1) chk("req_timeout", {31'd0, imem_req}, 32'd1);
   endtask

   // Fetch one word at the expected address, then check the S_VALID view.
   task automatic fetch(input logic [31:0] addr, input logic [31:0] word);
      wait_req();
      chk("fetch_addr", imem_addr, addr);
      imem_ack   = 1'b1;
      imem_rdata = word;
      @(negedge clk);
      imem_ack   = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      chk("valid_flag", {31'd0, instr_valid}, 32'd1);
      chk("valid_req", {31'd0, imem_req}, 32'd0);
      chk("valid_instr", instr, word);
      chk("valid_pc", pc, addr);
      chk("pc_plus4", pc_plus4, addr + 32'd4);
   endtask

   initial begin
      logic [31:0] a;
      pass_cnt = 0;
      total_cnt = 0;
      rst_n = 1'b0;
      stall = 1'b0;
      branch_taken = 1'b0;
      jump = 1'b0;
      jr = 1'b0;
      jr_target = 32'h0000_0000;
      imem_ack = 1'b0;
      imem_rdata = 32'h0000_0000;

      set_vec(0,  32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0,          32'h0000_0004);
      set_vec(1,  32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0,          32'h0000_0008);
      set_vec(2,  32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h0000_0100,  32'h0000_0100);
`ifdef PC_BRANCH_SIGN_EXT_EN
      set_vec(3,  32'h0000_FFFF, 1'b1, 1'b0, 1'b0, 32'h0,          32'h0000_0100);
`else
      set_vec(3,  32'h0000_FFFF, 1'b1, 1'b0, 1'b0, 32'h0,          32'h0004_0100);
`endif
      set_vec(4,  32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h3000_0000,  32'h3000_0000);
      set_vec(5,  32'h0800_0010, 1'b0, 1'b1, 1'b0, 32'h0,          32'h3000_0040);
      set_vec(6,  32'h0800_0010, 1'b1, 1'b1, 1'b1, 32'h0000_1237,  32'h0000_1234);
      set_vec(7,  32'h1000_0010, 1'b1, 1'b0, 1'b0, 32'h0,          32'h0000_1278);
      set_vec(8,  32'h0000_0003, 1'b1, 1'b1, 1'b0, 32'h0,          32'h0000_000C);
      set_vec(9,  32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFC);
      set_vec(10, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0,          32'h0000_0000);
`ifdef PC_BRANCH_SIGN_EXT_EN
      set_vec(11, 32'h0000_8000, 1'b1, 1'b0, 1'b0, 32'h0,          32'hFFFE_0004);
`else
      set_vec(11, 32'h0000_8000, 1'b1, 1'b0, 1'b0, 32'h0,          32'h0002_0004);
`endif

      // Reset state and fetch latency.
      @(negedge clk);
      @(negedge clk);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_pc", pc, 32'h0000_0000);
      chk("rst_instr", instr, 32'h0000_0000);
      rst_n = 1'b1;
      #1;
      chk("idle_req", {31'd0, imem_req}, 32'd0);
      @(negedge clk);
      chk("first_req", {31'd0, imem_req}, 32'd1);

      a = 32'h0000_0000;
      for (int i = 0; i < 12; i++) begin
         fetch(a, vecs[i].word);
         branch_taken = vecs[i].br;
         jump         = vecs[i].jmp;
         jr           = vecs[i].jrr;
         jr_target    = vecs[i].jrt;
         @(negedge clk);
         branch_taken = 1'b0;
         jump         = 1'b0;
         jr           = 1'b0;
         chk("req_after_valid", {31'd0, imem_req}, 32'd1);
         chk("next_addr", imem_addr, vecs[i].nxt);
         a = vecs[i].nxt;
      end

      // Stall holds S_VALID; a spurious ack and a taken branch are both ignored.
      fetch(a, 32'h0000_0001);
      stall = 1'b1;
      branch_taken = 1'b1;
      for (int i = 0; i < 3; i++) begin
         imem_ack = (i == 1);
         imem_rdata = 32'h5A5A_5A5A;
         @(negedge clk);
         chk("stall_pc", pc, a);
         chk("stall_instr", instr, 32'h0000_0001);
         chk("stall_req", {31'd0, imem_req}, 32'd0);
         chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      end
      imem_ack = 1'b0;
      stall = 1'b0;
      branch_taken = 1'b0;
      @(negedge clk);
      a = a + 32'd4;
      chk("unstall_addr", imem_addr, a);

      // Memory wait states: req/addr stable, controls in S_REQ ignored.
      jr = 1'b1;
      jr_target = 32'h0000_5550;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("wait_req", {31'd0, imem_req}, 32'd1);
         chk("wait_addr", imem_addr, a);
         chk("wait_valid", {31'd0, instr_valid}, 32'd0);
      end
      jr = 1'b0;
      fetch(a, 32'h0000_0002);
      @(negedge clk);
      a = a + 32'd4;
      chk("post_wait_addr", imem_addr, a);

      // Asynchronous reset in the middle of S_REQ, with an ack in flight.
      imem_ack = 1'b1;
      imem_rdata = 32'h1111_2222;
      rst_n = 1'b0;
      #1;
      chk("midreq_req", {31'd0, imem_req}, 32'd0);
      chk("midreq_pc", pc, 32'h0000_0000);
      chk("midreq_valid", {31'd0, instr_valid}, 32'd0);
      @(negedge clk);
      chk("midreq_instr", instr, 32'h0000_0000);
      imem_ack = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rerst_addr", imem_addr, 32'h0000_0000);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
